// File: rtl/uart_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser_if
//   Byte-level handshake bundle between the UART blocks and uart_cmd_parser.
//
//   rx_valid / rx_data : one-cycle strobe plus byte from the receiver.
//   tx_valid / tx_data : reply byte offered to the transmitter.
//   tx_ready           : transmitter accepts tx_data; a byte moves on any
//                        cycle where tx_valid && tx_ready.
//
//   master : the UART side (drives received bytes, accepts reply bytes).
//   slave  : the command parser.
// ---------------------------------------------------------------------------
interface uart_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//   Assembles command frames from received UART bytes, executes them and
//   returns a two-byte reply (status, data) to the UART transmitter.
//
//   Frame: SYNC, CMD, ARG[, SUM]   with SUM = CMD ^ ARG
//   Commands: 01 write LEDs, 02 read LEDs, 03 echo ARG, 04 read err_cnt.
//   Status byte: 8'h06 on success, 8'h15 on error.
//
//   Build option: define UART_CMD_CHECKSUM_EN for the 4-byte frame with
//   SUM validation. Without it the frame is 3 bytes and neither the
//   GET_SUM state nor the SUM register exist.
//
//   Ports:
//     clk     : system clock (shared with uart_rx / uart_tx)
//     resetn  : asynchronous active-low reset
//     bus     : rx byte strobe and tx byte handshake (slave modport)
//     leds    : LED register
//     err_cnt : saturating error counter
//     busy    : high whenever the parser is not idle
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         LED_W          = 3
) (
    input  logic             clk,
    input  logic             resetn,
    uart_cmd_parser_if.slave bus,
    output logic [LED_W-1:0] leds,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      ST_ACK  = 8'h06;
    localparam logic [7:0]      ST_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_ARG = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
        GET_SUM = 3'd3,
`endif
        EXEC    = 3'd4,
        TX_STAT = 3'd5,
        TX_DATA = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
`endif
    logic [7:0]       stat_q, stat_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       err_q, err_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             err_evt;
    logic             in_frame;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        arg_d    = arg_q;
`ifdef UART_CMD_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        stat_d   = stat_q;
        data_d   = data_q;
        leds_d   = leds_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_evt  = 1'b0;
        in_frame = 1'b0;

        case (state_q)
            IDLE: begin
                // Anything but the sync marker is line noise and is ignored.
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = GET_CMD;
                    cnt_d   = '0;
                end
            end
            GET_CMD: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    state_d = GET_ARG;
                end
            end
            GET_ARG: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    arg_d   = bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                    state_d = GET_SUM;
`else
                    state_d = EXEC;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            GET_SUM: begin
                in_frame = 1'b1;
                if (bus.rx_valid) begin
                    sum_d   = bus.rx_data;
                    state_d = EXEC;
                end
            end
`endif
            EXEC: begin
                state_d = TX_STAT;
                stat_d  = ST_ACK;
                err_evt = bus.rx_valid;
`ifdef UART_CMD_CHECKSUM_EN
                if (sum_q != (cmd_q ^ arg_q)) begin
                    stat_d  = ST_NAK;
                    data_d  = 8'hEE;
                    err_evt = 1'b1;
                end else
`endif
                begin
                    case (cmd_q)
                        8'h01: begin
                            leds_d = arg_q[LED_W-1:0];
                            data_d = 8'(arg_q[LED_W-1:0]);
                        end
                        8'h02:   data_d = 8'(leds_q);
                        8'h03:   data_d = arg_q;
                        // Reports the count as it stood before this cycle.
                        8'h04:   data_d = err_q;
                        default: begin
                            stat_d  = ST_NAK;
                            data_d  = cmd_q;
                            err_evt = 1'b1;
                        end
                    endcase
                end
            end
            TX_STAT: begin
                err_evt = bus.rx_valid;
                if (bus.tx_ready) state_d = TX_DATA;
            end
            TX_DATA: begin
                err_evt = bus.rx_valid;
                if (bus.tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog: an accepted byte restarts it, otherwise the
        // frame is abandoned after TIMEOUT_CYCLES silent cycles.
        if (in_frame) begin
            if (bus.rx_valid) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                err_evt = 1'b1;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end

        // Several error sources in one cycle still count as a single event.
        if (err_evt && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            arg_q   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q   <= '0;
`endif
            stat_q  <= '0;
            data_q  <= '0;
            leds_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
            stat_q  <= stat_d;
            data_q  <= data_d;
            leds_q  <= leds_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.tx_valid = (state_q == TX_STAT) || (state_q == TX_DATA);
    assign leds         = leds_q;
    assign err_cnt      = err_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        bus.tx_data = 8'h00;
        if (state_q == TX_STAT)      bus.tx_data = stat_q;
        else if (state_q == TX_DATA) bus.tx_data = data_q;
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Directed vector table, hand-written corner sequences (timeouts, bytes
//   arriving while busy, resets mid-frame / mid-reply, saturation) and a
//   randomized phase checked against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int         TO   = 50;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic [2:0] leds;
    logic [7:0] err_cnt;
    logic       busy;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO),
        .LED_W          (3)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .leds    (leds),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] got[$];
    bit         rnd_ready = 1'b0;
    logic [2:0] leds_m = '0;
    logic [7:0] err_m  = '0;

    typedef struct {
        logic [7:0] junk;
        logic [7:0] cmd;
        logic [7:0] arg;
        bit         sum_ok;
        int         stall;
        logic [7:0] st;
        logic [7:0] dt;
        logic [2:0] leds;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[10];

    // Reply byte collector: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (resetn && bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected end earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom_range(0, 255));
        repeat (gap) tick();
    endtask

    function automatic logic [7:0] frame_sum(input logic [7:0] c, a, input bit ok);
        return ok ? (c ^ a) : (c ^ a ^ 8'h5A);
    endfunction

    task automatic send_frame(input logic [7:0] c, a, input bit ok, input int gap);
        send_byte(SYNC, gap);
        send_byte(c, gap);
        if (CK) begin
            send_byte(a, gap);
            send_byte(frame_sum(c, a, ok), 0);
        end else begin
            send_byte(a, 0);
        end
    endtask

    task automatic bump_err();
        if (err_m != 8'hFF) err_m = err_m + 8'd1;
    endtask

    // Reference behaviour of one complete frame.
    task automatic model_frame(input logic [7:0] c, a, s, output logic [7:0] st, dt);
        bit e;
        e  = 1'b0;
        st = 8'h06;
        if (CK && (s != (c ^ a))) begin
            st = 8'h15; dt = 8'hEE; e = 1'b1;
        end else if (c == 8'h01) begin
            leds_m = a[2:0]; dt = {5'd0, a[2:0]};
        end else if (c == 8'h02) begin
            dt = {5'd0, leds_m};
        end else if (c == 8'h03) begin
            dt = a;
        end else if (c == 8'h04) begin
            dt = err_m;
        end else begin
            st = 8'h15; dt = c; e = 1'b1;
        end
        if (e) bump_err();
    endtask

    task automatic wait_reply(input string tag, input logic [7:0] st, dt);
        int n;
        logic [7:0] b;
        n = 0;
        while (got.size() < 2 && n < 400) begin
            tick();
            n++;
        end
        if (got.size() < 2) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_reply: got %0d bytes expected 2", tag, got.size());
            got.delete();
        end else begin
            b = got.pop_front();
            chk({tag, "_stat"}, b, st);
            b = got.pop_front();
            chk({tag, "_data"}, b, dt);
        end
    endtask

    task automatic wait_txv(input string tag);
        int n;
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_txv"}, bus.tx_valid, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] c, a, input bit ok, input int gap);
        logic [7:0] st, dt;
        model_frame(c, a, frame_sum(c, a, ok), st, dt);
        send_frame(c, a, ok, gap);
        wait_reply(tag, st, dt);
        chk({tag, "_leds"}, leds, leds_m);
        chk({tag, "_err"}, err_cnt, err_m);
        chk({tag, "_busy"}, busy, 1'b0);
        $display("%s: cmd=%02h arg=%02h sum_ok=%0d -> expect %02h %02h leds=%0d err=%0d",
                 tag, c, a, ok, st, dt, leds_m, err_m);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_txv"}, bus.tx_valid, 1'b0);
        chk({tag, "_txd"}, bus.tx_data, 8'h00);
        chk({tag, "_leds"}, leds, 3'd0);
        chk({tag, "_err"}, err_cnt, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
        leds_m = '0;
        err_m  = '0;
        got.delete();
        $display("%s: outputs cleared by reset", tag);
    endtask

    initial begin
        logic [7:0] e1;
        logic [2:0] l2;
        logic [2:0] prev_leds;
        logic [7:0] st, dt, j, c;
        int         sel;

        e1 = CK ? 8'd1 : 8'd0;
        l2 = CK ? 3'd5 : 3'd7;
        tbl[0] = '{8'h00, 8'h01, 8'h05, 1'b1, 0,  8'h06, 8'h05, 3'd5, 8'd0};
        tbl[1] = '{8'h00, 8'h02, 8'h00, 1'b1, 10, 8'h06, 8'h05, 3'd5, 8'd0};
        tbl[2] = '{8'h00, 8'h01, 8'h07, 1'b0, 0,  CK ? 8'h15 : 8'h06, CK ? 8'hEE : 8'h07, l2, e1};
        tbl[3] = '{8'h00, 8'h04, 8'h00, 1'b1, 0,  8'h06, e1,    l2,   e1};
        tbl[4] = '{8'h33, 8'h03, 8'h3C, 1'b1, 0,  8'h06, 8'h3C, l2,   e1};
        tbl[5] = '{8'h00, 8'h09, 8'h11, 1'b1, 0,  8'h15, 8'h09, l2,   e1 + 8'd1};
        tbl[6] = '{8'h00, 8'h01, 8'hA5, 1'b1, 0,  8'h06, 8'h05, 3'd5, e1 + 8'd1};
        tbl[7] = '{8'h00, 8'h01, 8'h02, 1'b1, 3,  8'h06, 8'h02, 3'd2, e1 + 8'd1};
        tbl[8] = '{8'h00, 8'h02, 8'hFF, 1'b1, 0,  8'h06, 8'h02, 3'd2, e1 + 8'd1};
        tbl[9] = '{8'h00, 8'h04, 8'h00, 1'b1, 0,  8'h06, e1 + 8'd1, 3'd2, e1 + 8'd1};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        resetn       = 1'b1;
        #1 resetn    = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        resetn = 1'b1;
        tick();

        // ---------------- vector table ----------------
        prev_leds = 3'd0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].junk != 8'h00) send_byte(tbl[i].junk, 2);
            if (tbl[i].stall > 0) bus.tx_ready = 1'b0;
            send_frame(tbl[i].cmd, tbl[i].arg, tbl[i].sum_ok, 1);
            if (tbl[i].stall > 0) begin
                chk($sformatf("vec%0d_exec_txv", i), bus.tx_valid, 1'b0);
                chk($sformatf("vec%0d_exec_leds", i), leds, prev_leds);
                tick();
                chk($sformatf("vec%0d_post_leds", i), leds, tbl[i].leds);
                for (int k = 0; k < tbl[i].stall; k++) begin
                    chk($sformatf("vec%0d_hold_txv", i), bus.tx_valid, 1'b1);
                    chk($sformatf("vec%0d_hold_txd", i), bus.tx_data, tbl[i].st);
                    tick();
                end
                bus.tx_ready = 1'b1;
            end
            wait_reply($sformatf("vec%0d", i), tbl[i].st, tbl[i].dt);
            chk($sformatf("vec%0d_leds", i), leds, tbl[i].leds);
            chk($sformatf("vec%0d_err", i), err_cnt, tbl[i].err);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
            prev_leds = tbl[i].leds;
            $display("vec%0d: cmd=%02h arg=%02h -> expect %02h %02h leds=%0d err=%0d",
                     i, tbl[i].cmd, tbl[i].arg, tbl[i].st, tbl[i].dt, tbl[i].leds, tbl[i].err);
        end
        leds_m = 3'd2;
        err_m  = e1 + 8'd1;

        // ---------------- inter-byte timeout ----------------
        send_byte(SYNC, 0);
        send_byte(8'h01, TO + 5);
        bump_err();
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_err", err_cnt, err_m);
        chk("timeout_no_tx", got.size(), 0);
        $display("timeout: frame abandoned, err=%0d", err_m);
        run_frame("after_timeout", 8'h03, 8'h5A, 1'b1, 0);

        // Longest legal gap, then one cycle too long.
        run_frame("gap_max", 8'h03, 8'h44, 1'b1, TO - 1);
        send_byte(SYNC, TO);
        bump_err();
        chk("gap_over_busy", busy, 1'b0);
        chk("gap_over_err", err_cnt, err_m);
        send_byte(8'h03, 4);
        chk("gap_over_no_tx", got.size(), 0);
        chk("gap_over_idle", busy, 1'b0);
        $display("gap_over: frame abandoned, err=%0d", err_m);

        // ---------------- byte arriving during EXEC ----------------
        model_frame(8'h09, 8'h00, frame_sum(8'h09, 8'h00, 1'b1), st, dt);
        send_frame(8'h09, 8'h00, 1'b1, 0);
        send_byte(8'h77, 0);
        wait_reply("exec_dual_err", st, dt);
        chk("exec_dual_err_cnt", err_cnt, err_m);
        $display("exec_dual_err: two error sources in one cycle, err=%0d", err_m);

        model_frame(8'h03, 8'h21, frame_sum(8'h03, 8'h21, 1'b1), st, dt);
        send_frame(8'h03, 8'h21, 1'b1, 0);
        send_byte(8'h77, 0);
        bump_err();
        wait_reply("exec_rx_err", st, dt);
        chk("exec_rx_err_cnt", err_cnt, err_m);
        $display("exec_rx_err: byte during EXEC, err=%0d", err_m);

        // ---------------- byte arriving during reply ----------------
        bus.tx_ready = 1'b0;
        model_frame(8'h03, 8'h66, frame_sum(8'h03, 8'h66, 1'b1), st, dt);
        send_frame(8'h03, 8'h66, 1'b1, 0);
        wait_txv("tx_rx");
        send_byte(8'h55, 0);
        bump_err();
        chk("tx_rx_err", err_cnt, err_m);
        chk("tx_rx_hold", bus.tx_data, 8'h06);
        bus.tx_ready = 1'b1;
        wait_reply("tx_rx", st, dt);
        chk("tx_rx_busy", busy, 1'b0);
        $display("tx_rx: byte during reply dropped, err=%0d", err_m);

        // ---------------- reset mid-frame ----------------
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        #2 resetn = 1'b0;
        #1;
        check_reset("rst_frame");
        tick();
        tick();
        resetn = 1'b1;
        run_frame("post_rst_frame", 8'h03, 8'hAA, 1'b1, 0);

        // ---------------- reset mid-reply ----------------
        run_frame("pre_rst_w", 8'h01, 8'h06, 1'b1, 0);
        run_frame("pre_rst_e", 8'h0B, 8'h00, 1'b1, 0);
        bus.tx_ready = 1'b0;
        send_frame(8'h03, 8'hAA, 1'b1, 0);
        wait_txv("rst_reply");
        #2 resetn = 1'b0;
        #1;
        check_reset("rst_reply");
        tick();
        tick();
        resetn = 1'b1;
        bus.tx_ready = 1'b1;
        run_frame("post_rst_reply", 8'h03, 8'hAA, 1'b1, 0);

        // ---------------- randomized frames ----------------
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                j = 8'($urandom_range(0, 255));
                if (j == SYNC) j = 8'h5B;
                send_byte(j, int'($urandom_range(0, 3)));
            end
            sel = int'($urandom_range(0, 5));
            c   = (sel < 4) ? 8'(sel + 1) : 8'($urandom_range(0, 255));
            run_frame($sformatf("rnd%0d", i), c, 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)));
        end
        rnd_ready    = 1'b0;
        bus.tx_ready = 1'b1;

        // ---------------- error counter saturation ----------------
        for (int i = 0; i < 260; i++) begin
            run_frame($sformatf("sat%0d", i), 8'hFF, 8'h00, 1'b1, 0);
        end
        chk("sat_final", err_cnt, 8'hFF);
        run_frame("sat_read", 8'h04, 8'h00, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
